// File: rtl/dma_xfer_ctrl.sv
// ============================================================================
// Module   : dma_xfer_ctrl
// Function : Moves a block of 16-bit words between a valid/ready stream and an
//            openMSP430 DMA master port, in either direction.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dma_xfer_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [14:0]      base_addr,
  input  logic [CNT_W-1:0] word_cnt,
  input  logic             prio,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [15:0]      out_data,
  input  logic             out_ready,
  output logic             dma_en,
  output logic [1:0]       dma_we,
  output logic [14:0]      dma_addr,
  output logic [15:0]      dma_din,
  output logic             dma_priority,
  output logic             dma_wkup,
  input  logic             dma_ready,
  input  logic             dma_resp,
  input  logic [15:0]      dma_dout,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    REQ   = 3'd2,
    RCAPT = 3'd3,
    PUSH  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               dir_q, dir_d;
  logic               prio_q, prio_d;
  logic               error_q, error_d;
  logic [14:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        data_q, data_d;
  logic [15:0]        rdata_q, rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      prio_q  <= 1'b0;
      error_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      prio_q  <= prio_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    prio_d  = prio_q;
    error_d = error_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dir_d   = dir;
          prio_d  = prio;
          addr_d  = base_addr;
          cnt_d   = word_cnt;
          error_d = 1'b0;
          if (word_cnt == '0) state_d = DONE;
          else if (dir)       state_d = FETCH;
          else                state_d = REQ;
        end
      end
      FETCH: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dma_ready) begin
          // 15-bit word address wraps naturally from 0x7FFF to 0x0000
          addr_d = addr_q + 15'd1;
          cnt_d  = cnt_q - CNT_W'(1);
          if (dma_resp) begin
            error_d = 1'b1;
            state_d = DONE;
          end else if (dir_q) begin
            state_d = (cnt_q == CNT_W'(1)) ? DONE : FETCH;
          end else begin
            state_d = RCAPT;
          end
        end
      end
      RCAPT: begin
        rdata_d = dma_dout;
        state_d = PUSH;
      end
      PUSH: begin
        if (out_ready) state_d = (cnt_q == '0) ? DONE : REQ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All handshake outputs decode registered state only
  assign dma_en       = (state_q == REQ);
  assign dma_we       = (state_q == REQ && dir_q) ? 2'b11 : 2'b00;
  assign dma_addr     = addr_q;
  assign dma_din      = data_q;
  assign dma_priority = prio_q;
  assign dma_wkup     = (state_q == FETCH) || (state_q == REQ);
  assign in_ready     = (state_q == FETCH);
  assign out_valid    = (state_q == PUSH);
  assign out_data     = rdata_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign error        = error_q;

endmodule

`default_nettype wire
